cp0_intc: RTL and testbench
===========================

Name: cp0_intc

Overview:
- Parametrised CP0 interrupt and timer controller for the MIPS-style core.
- Owns Count/Compare with a prescaler, software interrupts, synchronised external IRQs with per-line level/edge mode, and IM/IE masking.
- A registered priority encoder drives an irq_req/irq_ack handshake to the exception logic.
- Produces the IP[7:0] field that the Cause register reflects.

Parameters:
- N_EXT, 4, external IRQ lines (1..4), mapped to IP[4+N_EXT-1:4]; unused IP bits read 0.
- COUNT_DIV, 2, clock cycles per Count increment (1..16).
- SYNC_STAGES, 2, flip-flop synchroniser depth on external IRQs (2..3).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  MTC0 write strobe, one cycle
- wr_addr  in  8  {reg[4:0],sel[2:0]}
- wr_data  in  32  MTC0 data
- rd_addr  in  8  MFC0 address
- rd_data  out  32  combinational read data
- ext_irq  in  N_EXT  asynchronous external requests, active-high
- perf_irq  in  1  performance-counter request (IP[2]), already synchronous
- count_dis  in  1  Cause.DC; freezes Count and prescaler
- status_im  in  8  Status.IM[7:0]
- status_ie  in  1  Status.IE
- status_exl  in  1  Status.EXL
- ip  out  8  pending vector to Cause[15:8]
- irq_req  out  1  registered interrupt request
- irq_id  out  3  registered index of highest-priority pending, unmasked IP bit
- irq_ack  in  1  one-cycle pulse: core has taken the interrupt

Behaviour:
- Reset (reset=0, async): Count=0, Compare=0xFFFFFFFF, prescaler=0, swi=0, edge_mode=0, edge latches=0, timer_pending=0, synchronisers=0, FSM=IDLE, irq_req=0, irq_id=0.
- Register map:
  - Count 9.0 (8'h48), RW.
  - Compare 11.0 (8'h58), RW.
  - Cause 13.0 (8'h68): write affects only bits [9:8] (swi); read returns {16'b0, ip, 8'b0}.
  - IrqCfg 22.0 (8'hB0): bits[N_EXT-1:0]=edge_mode RW; bits[16+N_EXT-1:16] read edge latch status, write-1-to-clear.
  - Unmapped reads return 0. Writes take effect on the following clock edge.
- Prescaler:
  - Counts 0..COUNT_DIV-1; tick when it equals COUNT_DIV-1, then wraps to 0.
  - Count increments by 1 on tick, wrapping 0xFFFFFFFF->0.
  - count_dis=1 holds both.
  - A Count write loads the value, resets the prescaler, and suppresses that cycle's increment.
- Timer:
  - timer_pending sets on the tick whose incremented Count equals Compare. This is edge semantics, not a level compare.
  - A Compare write clears it and wins over a simultaneous set.
  - Writing Count equal to Compare does not set it.
- External lines: each passes SYNC_STAGES flops.
  - Level mode: the IP bit is the synchronised level.
  - Edge mode: a rising edge of the synchronised signal sets the latch. The latch holds until W1C; an edge and a W1C in the same cycle leave it set.
  - Changing edge_mode does not clear the latch.
- ip = {ext bits padded to 4, timer_pending, perf_irq, swi[1:0]}.
- eligible = status_ie & ~status_exl & |(ip & status_im).
- irq_id = index of highest set bit of ip&status_im (7 highest); updated every cycle while FSM=IDLE, frozen otherwise.
- FSM:
  - IDLE: if eligible, go to REQ and set irq_req=1 next cycle.
  - REQ:
    - irq_ack=1: go to BUSY, irq_req=0.
    - eligible=0 without ack: go to IDLE, irq_req=0 (retraction allowed).
    - irq_id holds the value latched on entry.
  - BUSY: irq_req=0; wait for status_exl=1, then for status_exl=0 (ERET), then go to IDLE.
  - irq_ack outside REQ is ignored.
- Latency: IRQ pin assertion to irq_req=1 is SYNC_STAGES+1 cycles in level mode and SYNC_STAGES+2 in edge mode.

Decomposition:
- Package cp0_pkg holds:
  - CP0 address constants: ADDR_COUNT, ADDR_COMPARE, ADDR_CAUSE, ADDR_IRQCFG.
  - IP bit index constants: IP_SWI0, IP_PERF, IP_TIMER, IP_EXT0.
  - FSM state enum: IDLE, REQ, BUSY.
- Sub-module cp0_irq_line: synchroniser, edge detector and latch for one line, instantiated N_EXT times with a generate loop.

Test Plan:
- Timer, COUNT_DIV=2: write Compare=5, Count=0 -> timer_pending and ip[3] set 10 cycles later; with IM[3]=1, IE=1, EXL=0, irq_req rises the next cycle with irq_id=3. Then write Compare=100 -> ip[3]=0 next cycle.
- Level IRQ: ext_irq[1] high, IM[5]=1 -> irq_req=1 exactly 3 cycles after assertion, irq_id=5. Deassert before ack -> FSM returns to IDLE and irq_req drops.
- Edge IRQ: edge_mode[0]=1, 2-cycle pulse on ext_irq[0] -> IrqCfg bit16=1 persists after the pulse. Write 0x00010000 -> bit clears. Edge arriving in the same cycle as the clear -> bit stays 1.
- Priority/handshake: swi=2'b01 (ip[0]) and ext line 3 (ip[7]) pending, all IM set -> irq_id=7. irq_ack pulse -> irq_req=0. Raise EXL then drop EXL -> irq_req reasserts with irq_id=7 if still pending.
- Count freeze/wrap: Count=0xFFFFFFFF, COUNT_DIV=1 -> 0 after one cycle. count_dis=1 for 5 cycles -> Count unchanged. Write Count=Compare -> no timer_pending.
- Async reset mid-REQ: assert reset low with irq_req=1 -> irq_req, ip, Count all 0 immediately without a clock edge; after release Compare reads 0xFFFFFFFF.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 interrupt-controller definitions: register addresses, IP bit
// positions, handshake FSM states and the IP priority encoder.
package cp0_pkg;

    localparam logic [7:0] ADDR_COUNT   = 8'h48;
    localparam logic [7:0] ADDR_COMPARE = 8'h58;
    localparam logic [7:0] ADDR_CAUSE   = 8'h68;
    localparam logic [7:0] ADDR_IRQCFG  = 8'hB0;

    localparam int unsigned IP_SWI0  = 0;
    localparam int unsigned IP_PERF  = 2;
    localparam int unsigned IP_TIMER = 3;
    localparam int unsigned IP_EXT0  = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BUSY
    } irq_state_e;

    // Index of the highest set bit; 0 when nothing is set.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/cp0_irq_line.sv
// One external interrupt line: synchroniser, rising-edge detector and a
// sticky edge latch with write-1-to-clear.
module cp0_irq_line #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    input  logic edge_mode,
    input  logic clr,
    output logic pend,
    output logic latched
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   latch_q, latch_d;
    logic                   rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            latch_q <= latch_d;
        end
    end

    // A new edge outranks a simultaneous clear so no event is lost.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], irq_async};
        prev_d  = sync_q[SYNC_STAGES-1];
        rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
        latch_d = (latch_q & ~clr) | (edge_mode & rise);
        pend    = edge_mode ? latch_q : sync_q[SYNC_STAGES-1];
        latched = latch_q;
    end

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt and timer controller: Count/Compare with prescaler, software
// and external interrupts, IM/IE masking and the irq_req/irq_ack handshake.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int unsigned N_EXT       = 4,
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [7:0]       rd_addr,
    output logic [31:0]      rd_data,
    input  logic [N_EXT-1:0] ext_irq,
    input  logic             perf_irq,
    input  logic             count_dis,
    input  logic [7:0]       status_im,
    input  logic             status_ie,
    input  logic             status_exl,
    output logic [7:0]       ip,
    output logic             irq_req,
    output logic [2:0]       irq_id,
    input  logic             irq_ack
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]      count_q, count_d, compare_q, compare_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       swi_q, swi_d;
    logic [N_EXT-1:0] edge_mode_q, edge_mode_d;
    logic             timer_q, timer_d;
    irq_state_e       state_q, state_d;
    logic             exl_seen_q, exl_seen_d;
    logic             irq_req_q, irq_req_d;
    logic [2:0]       irq_id_q, irq_id_d;

    logic             wr_count, wr_compare, wr_cause, wr_irqcfg, tick, eligible;
    logic [N_EXT-1:0] ext_clr, ext_pend, ext_latch;
    logic [7:0]       masked;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            compare_q   <= 32'hFFFF_FFFF;
            presc_q     <= '0;
            swi_q       <= '0;
            edge_mode_q <= '0;
            timer_q     <= 1'b0;
            state_q     <= IDLE;
            exl_seen_q  <= 1'b0;
            irq_req_q   <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            presc_q     <= presc_d;
            swi_q       <= swi_d;
            edge_mode_q <= edge_mode_d;
            timer_q     <= timer_d;
            state_q     <= state_d;
            exl_seen_q  <= exl_seen_d;
            irq_req_q   <= irq_req_d;
            irq_id_q    <= irq_id_d;
        end
    end

    for (genvar g = 0; g < N_EXT; g++) begin : g_line
        cp0_irq_line #(.SYNC_STAGES(SYNC_STAGES)) u_line (
            .clk       (clk),
            .reset     (reset),
            .irq_async (ext_irq[g]),
            .edge_mode (edge_mode_q[g]),
            .clr       (ext_clr[g]),
            .pend      (ext_pend[g]),
            .latched   (ext_latch[g])
        );
    end

    // Register writes, prescaled Count and the edge-triggered timer flag.
    always_comb begin
        wr_count    = wr_en && (wr_addr == ADDR_COUNT);
        wr_compare  = wr_en && (wr_addr == ADDR_COMPARE);
        wr_cause    = wr_en && (wr_addr == ADDR_CAUSE);
        wr_irqcfg   = wr_en && (wr_addr == ADDR_IRQCFG);
        tick        = 1'b0;
        count_d     = count_q;
        presc_d     = presc_q;
        if (wr_count) begin
            count_d = wr_data;
            presc_d = '0;
        end else if (!count_dis) begin
            if (presc_q == PRESC_MAX) begin
                tick    = 1'b1;
                presc_d = '0;
                count_d = count_q + 32'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        compare_d   = wr_compare ? wr_data : compare_q;
        timer_d     = timer_q;
        if (tick && (count_d == compare_q)) timer_d = 1'b1;
        if (wr_compare) timer_d = 1'b0;
        swi_d       = wr_cause ? wr_data[9:8] : swi_q;
        edge_mode_d = wr_irqcfg ? wr_data[N_EXT-1:0] : edge_mode_q;
        ext_clr     = wr_irqcfg ? wr_data[16 +: N_EXT] : '0;
    end

    always_comb begin
        ip                  = '0;
        ip[IP_SWI0 +: 2]    = swi_q;
        ip[IP_PERF]         = perf_irq;
        ip[IP_TIMER]        = timer_q;
        for (int i = 0; i < int'(N_EXT); i++) ip[IP_EXT0 + i] = ext_pend[i];
        masked   = ip & status_im;
        eligible = status_ie & ~status_exl & (|masked);
    end

    // Handshake FSM; BUSY waits for the exception entry and its ERET.
    always_comb begin
        state_d    = state_q;
        exl_seen_d = 1'b0;
        case (state_q)
            IDLE: if (eligible) state_d = REQ;
            REQ: begin
                if (irq_ack)       state_d = BUSY;
                else if (!eligible) state_d = IDLE;
            end
            BUSY: begin
                exl_seen_d = exl_seen_q | status_exl;
                if (exl_seen_q && !status_exl) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_req_d = (state_d == REQ);
        irq_id_d  = (state_q == IDLE) ? prio_enc(masked) : irq_id_q;
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_COUNT:   rd_data = count_q;
            ADDR_COMPARE: rd_data = compare_q;
            ADDR_CAUSE:   rd_data = {16'b0, ip, 8'b0};
            ADDR_IRQCFG: begin
                for (int i = 0; i < int'(N_EXT); i++) begin
                    rd_data[i]      = edge_mode_q[i];
                    rd_data[16 + i] = ext_latch[i];
                end
            end
            default:      rd_data = '0;
        endcase
    end

    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed scoreboard bench for cp0_intc: a COUNT_DIV=2 instance plus a
// COUNT_DIV=1 instance sharing all inputs.
module tb_cp0_intc;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data, rd_data1;
    logic [3:0]  ext_irq;
    logic        perf_irq, count_dis, status_ie, status_exl, irq_ack;
    logic [7:0]  status_im;
    logic [7:0]  ip, ip1;
    logic        irq_req, irq_req1;
    logic [2:0]  irq_id, irq_id1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] d0, d1;

    always #5 clk = ~clk;

    cp0_intc #(.N_EXT(4), .COUNT_DIV(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .ext_irq(ext_irq), .perf_irq(perf_irq),
        .count_dis(count_dis), .status_im(status_im), .status_ie(status_ie),
        .status_exl(status_exl), .ip(ip), .irq_req(irq_req), .irq_id(irq_id),
        .irq_ack(irq_ack)
    );

    cp0_intc #(.N_EXT(4), .COUNT_DIV(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data1), .ext_irq(ext_irq), .perf_irq(perf_irq),
        .count_dis(count_dis), .status_im(status_im), .status_ie(status_ie),
        .status_exl(status_exl), .ip(ip1), .irq_req(irq_req1), .irq_id(irq_id1),
        .irq_ack(irq_ack)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] r0, output logic [31:0] r1);
        rd_addr = a;
        #1;
        r0 = rd_data;
        r1 = rd_data1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        ext_irq = '0; perf_irq = 1'b0; count_dis = 1'b0; status_im = '0;
        status_ie = 1'b0; status_exl = 1'b0; irq_ack = 1'b0;

        // Reset values
        #12;
        push("rst_irq_req", 32'(1'b0)); check(32'(irq_req));
        push("rst_irq_id", 32'(3'd0)); check(32'(irq_id));
        push("rst_ip", 32'(8'h00)); check(32'(ip));
        push("rst_ip1", 32'(8'h00)); check(32'(ip1));
        push("rst_irq_req1", 32'(1'b0)); check(32'(irq_req1));
        push("rst_irq_id1", 32'(3'd0)); check(32'(irq_id1));
        reset = 1'b1;
        tick();
        rd(ADDR_COMPARE, d0, d1); push("rst_compare", 32'hFFFF_FFFF); check(d0);
        rd(ADDR_COUNT, d0, d1); push("rst_count", 32'h0); check(d0);

        // Timer match, request, Compare write clears
        status_im = 8'h08; status_ie = 1'b1;
        wr(ADDR_COMPARE, 32'd5);
        wr(ADDR_COUNT, 32'd0);
        repeat (9) tick();
        push("timer_ip_early", 32'(8'h00)); check(32'(ip));
        tick();
        push("timer_ip_set", 32'(8'h08)); check(32'(ip));
        rd(ADDR_COUNT, d0, d1); push("timer_count", 32'd5); check(d0);
        tick();
        push("timer_irq_req", 32'(1'b1)); check(32'(irq_req));
        push("timer_irq_id", 32'(3'd3)); check(32'(irq_id));
        wr(ADDR_COMPARE, 32'd100);
        push("timer_ip_clr", 32'(8'h00)); check(32'(ip));
        tick();
        push("timer_retract", 32'(1'b0)); check(32'(irq_req));
        status_im = 8'h00;
        wr(ADDR_COMPARE, 32'h8000_0000);

        // Level-mode line 1: latency and retraction
        status_im = 8'h20;
        ext_irq = 4'b0010;
        tick(); tick();
        push("lvl_req_early", 32'(1'b0)); check(32'(irq_req));
        tick();
        push("lvl_req", 32'(1'b1)); check(32'(irq_req));
        push("lvl_id", 32'(3'd5)); check(32'(irq_id));
        ext_irq = 4'b0000;
        tick(); tick();
        push("lvl_req_hold", 32'(1'b1)); check(32'(irq_req));
        tick();
        push("lvl_req_drop", 32'(1'b0)); check(32'(irq_req));
        status_im = 8'h00;

        // Edge-mode line 0: latch, W1C, edge concurrent with clear
        wr(ADDR_IRQCFG, 32'h0000_0001);
        ext_irq = 4'b0001;
        tick(); tick();
        ext_irq = 4'b0000;
        repeat (4) tick();
        rd(ADDR_IRQCFG, d0, d1); push("edge_latch", 32'h0001_0001); check(d0);
        push("edge_ip", 32'(8'h10)); check(32'(ip));
        wr(ADDR_IRQCFG, 32'h0001_0001);
        rd(ADDR_IRQCFG, d0, d1); push("edge_w1c", 32'h0000_0001); check(d0);
        push("edge_ip_clr", 32'(8'h00)); check(32'(ip));
        ext_irq = 4'b0001;
        tick(); tick();
        wr(ADDR_IRQCFG, 32'h0001_0001);
        rd(ADDR_IRQCFG, d0, d1); push("edge_vs_clr", 32'h0001_0001); check(d0);
        ext_irq = 4'b0000;
        wr(ADDR_IRQCFG, 32'h0001_0000);
        rd(ADDR_IRQCFG, d0, d1); push("edge_cleanup", 32'h0); check(d0);

        // Count wrap (div 1), freeze, Count==Compare write
        wr(ADDR_COUNT, 32'hFFFF_FFFF);
        rd(ADDR_COUNT, d0, d1); push("wrap_pre", 32'hFFFF_FFFF); check(d1);
        tick();
        rd(ADDR_COUNT, d0, d1); push("wrap_zero", 32'h0); check(d1);
        count_dis = 1'b1;
        wr(ADDR_COUNT, 32'h0000_1234);
        repeat (5) tick();
        rd(ADDR_COUNT, d0, d1);
        push("freeze_div2", 32'h0000_1234); check(d0);
        push("freeze_div1", 32'h0000_1234); check(d1);
        count_dis = 1'b0;
        repeat (3) tick();
        rd(ADDR_COUNT, d0, d1);
        push("resume_div1", 32'h0000_1237); check(d1);
        push("resume_div2", 32'h0000_1235); check(d0);
        wr(ADDR_COUNT, 32'h8000_0000);
        tick(); tick();
        push("cnt_eq_cmp_ip", 32'(8'h00)); check(32'(ip));
        push("cnt_eq_cmp_ip1", 32'(8'h00)); check(32'(ip1));
        wr(ADDR_COUNT, 32'h0);

        // Priority and handshake through EXL/ERET
        status_ie = 1'b0; status_im = 8'hFF;
        ext_irq = 4'b1000;
        wr(ADDR_CAUSE, 32'h0000_0100);
        tick(); tick();
        push("prio_ip", 32'(8'h81)); check(32'(ip));
        rd(ADDR_CAUSE, d0, d1); push("prio_cause", 32'h0000_8100); check(d0);
        status_ie = 1'b1;
        tick();
        push("prio_req", 32'(1'b1)); check(32'(irq_req));
        push("prio_id", 32'(3'd7)); check(32'(irq_id));
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        push("ack_drop", 32'(1'b0)); check(32'(irq_req));
        tick(); tick();
        push("busy_hold", 32'(1'b0)); check(32'(irq_req));
        status_exl = 1'b1;
        tick(); tick();
        status_exl = 1'b0;
        tick();
        push("eret_idle", 32'(1'b0)); check(32'(irq_req));
        tick();
        push("rereq", 32'(1'b1)); check(32'(irq_req));
        push("rereq_id", 32'(3'd7)); check(32'(irq_id));

        // Async reset while requesting
        reset = 1'b0;
        #1;
        push("arst_req", 32'(1'b0)); check(32'(irq_req));
        push("arst_ip", 32'(8'h00)); check(32'(ip));
        push("arst_id", 32'(3'd0)); check(32'(irq_id));
        rd(ADDR_COUNT, d0, d1); push("arst_count", 32'h0); check(d0);
        reset = 1'b1;
        tick();
        rd(ADDR_COMPARE, d0, d1); push("arst_compare", 32'hFFFF_FFFF); check(d0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
